// File: rtl/output_seg_led_if.sv
// output_seg_led_if: CPU-side display words in, board-side serial chain waveforms out.
// master = the side that supplies display words and receives the chain pins,
// slave  = the display driver itself.
interface output_seg_led_if;
    logic [31:0] seg_data;
    logic [7:0]  seg_point;
    logic [7:0]  seg_blank;
    logic [15:0] led_data;

    logic        seg_clk;
    logic        seg_sout;
    logic        seg_pen;
    logic        seg_clrn;
    logic        led_clk;
    logic        led_sout;
    logic        led_pen;
    logic        led_clrn;
    logic        busy;

    modport master (
        output seg_data, seg_point, seg_blank, led_data,
        input  seg_clk, seg_sout, seg_pen, seg_clrn,
        input  led_clk, led_sout, led_pen, led_clrn,
        input  busy
    );

    modport slave (
        input  seg_data, seg_point, seg_blank, led_data,
        output seg_clk, seg_sout, seg_pen, seg_clrn,
        output led_clk, led_sout, led_pen, led_clrn,
        output busy
    );
endinterface

// File: rtl/output_seg_led.sv
// output_seg_led: serial driver for the 8-digit 7-segment chain and the 16-LED chain.
// Snapshots the display words, hex-decodes them, shifts 64 bit slots MSB-first
// (digit 7 first), then pulses the latch. A frame is sent once after reset and
// whenever the live inputs differ from the last snapshot.
// Optional feature macro: OUTPUT_SEG_LED_CHAIN_EN enables the LED chain and makes
// led_data part of change detection; without it the LED pins are held idle.
module output_seg_led #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    output_seg_led_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic        pending;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [63:0] seg_shift;
    logic [63:0] seg_word;
    logic [31:0] snap_data;
    logic [7:0]  snap_point;
    logic [7:0]  snap_blank;
    logic        changed;

    logic        seg_clk_r;
    logic        seg_sout_r;
    logic        seg_pen_r;
    logic        clrn_r;
    logic        busy_r;

    logic        div_last;
    logic        start;
    logic        load_exit;
    logic        slot_rise;
    logic        slot_end;
    logic        last_slot;
    logic        latch_end;

    // Active-low {g,f,e,d,c,b,a} for one hex digit (0 = segment lit).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // One chain byte {dp,g,f,e,d,c,b,a}; a blanked digit is fully dark.
    function automatic logic [7:0] digit_byte(input logic [3:0] nib, input logic point,
                                              input logic blank);
        logic [7:0] b;
        if (blank) begin
            b = '1;
        end else begin
            b = {~point, hex_to_seg(nib)};
        end
        return b;
    endfunction

    // Decode the live inputs into the 64-bit segment word, digit 7 in the top byte.
    always_comb begin
        seg_word = '1;
        for (int unsigned i = 0; i < 8; i++) begin
            seg_word[8*i +: 8] = digit_byte(bus.seg_data[4*i +: 4], bus.seg_point[i],
                                            bus.seg_blank[i]);
        end
    end

    assign div_last  = (div_cnt == DIV_LAST);
    assign start     = (state == IDLE) && (pending || changed);
    assign load_exit = (state == LOAD);
    assign slot_rise = (state == SHIFT) && div_last && !seg_clk_r;
    assign slot_end  = (state == SHIFT) && div_last && seg_clk_r;
    assign last_slot = (bit_cnt == 6'd63);
    assign latch_end = (state == LATCH) && div_last;

    // Frame sequencer: snapshot, slot timing, segment chain pins and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            seg_shift  <= '1;
            snap_data  <= '0;
            snap_point <= '0;
            snap_blank <= '0;
            seg_clk_r  <= 1'b0;
            seg_sout_r <= 1'b1;
            seg_pen_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_data  <= bus.seg_data;
                        snap_point <= bus.seg_point;
                        snap_blank <= bus.seg_blank;
                        seg_shift  <= seg_word;
                        pending    <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    seg_sout_r <= seg_shift[63];
                    seg_shift  <= {seg_shift[62:0], 1'b1};
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    seg_clk_r  <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!seg_clk_r) begin
                            seg_clk_r <= 1'b1;
                        end else begin
                            seg_clk_r <= 1'b0;
                            bit_cnt   <= bit_cnt + 6'd1;
                            if (last_slot) begin
                                seg_sout_r <= 1'b1;
                                seg_pen_r  <= 1'b1;
                                state      <= LATCH;
                            end else begin
                                seg_sout_r <= seg_shift[63];
                                seg_shift  <= {seg_shift[62:0], 1'b1};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt   <= '0;
                        seg_pen_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Chain clears follow reset one cycle late; both chains share this register.
    always_ff @(posedge clk) begin
        clrn_r <= ~rst;
    end

    assign bus.seg_clk  = seg_clk_r;
    assign bus.seg_sout = seg_sout_r;
    assign bus.seg_pen  = seg_pen_r;
    assign bus.seg_clrn = clrn_r;
    assign bus.busy     = busy_r;

`ifdef OUTPUT_SEG_LED_CHAIN_EN
    logic [15:0] snap_led;
    logic [15:0] led_shift;
    logic        led_clk_r;
    logic        led_sout_r;
    logic        led_pen_r;

    assign changed = {bus.seg_data, bus.seg_point, bus.seg_blank, bus.led_data} !=
                     {snap_data, snap_point, snap_blank, snap_led};

    // LED chain rides on the segment slot strobes; its clock runs only in slots 0..15
    // and the 1-filled shifter leaves sout high for the remaining slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_led   <= '0;
            led_shift  <= '1;
            led_clk_r  <= 1'b0;
            led_sout_r <= 1'b1;
            led_pen_r  <= 1'b0;
        end else begin
            if (start) begin
                snap_led  <= bus.led_data;
                led_shift <= ~bus.led_data;
            end else if (load_exit || (slot_end && !last_slot)) begin
                led_sout_r <= led_shift[15];
                led_shift  <= {led_shift[14:0], 1'b1};
            end

            if (slot_rise && (bit_cnt < 6'd16)) begin
                led_clk_r <= 1'b1;
            end else if (slot_end) begin
                led_clk_r <= 1'b0;
            end

            if (slot_end && last_slot) begin
                led_sout_r <= 1'b1;
                led_pen_r  <= 1'b1;
            end else if (latch_end) begin
                led_pen_r <= 1'b0;
            end
        end
    end

    assign bus.led_clk  = led_clk_r;
    assign bus.led_sout = led_sout_r;
    assign bus.led_pen  = led_pen_r;
    assign bus.led_clrn = clrn_r;
`else
    logic unused_led_data;

    assign unused_led_data = ^{bus.led_data, load_exit, slot_rise, latch_end};
    assign changed = {bus.seg_data, bus.seg_point, bus.seg_blank} !=
                     {snap_data, snap_point, snap_blank};

    assign bus.led_clk  = 1'b0;
    assign bus.led_sout = 1'b1;
    assign bus.led_pen  = 1'b0;
    assign bus.led_clrn = clrn_r;
`endif

endmodule

// File: tb/tb_output_seg_led.sv
// tb_output_seg_led: table-driven and randomized frame checks for output_seg_led.
// Captured chain bits are compared with a reference built from the lit-segment
// letter lists of each hex digit.
`timescale 1ns/1ps
module tb_output_seg_led;

    localparam int unsigned CLK_DIV   = 2;
    localparam int          FRAME_LEN = 1 + 128 * CLK_DIV + CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    output_seg_led_if bus();

    output_seg_led #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    string lit_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                             "abc", "abcdefg", "abcdfg", "abcefg", "cdefg", "adef",
                             "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] model_byte(input int unsigned val, input logic dp,
                                              input logic blank);
        logic [7:0] b;
        string s;
        b = 8'hFF;
        if (blank) return b;
        s = lit_segs[val];
        for (int k = 0; k < s.len(); k++) b[int'(s[k]) - 97] = 1'b0;
        if (dp) b[7] = 1'b0;
        return b;
    endfunction

    // Bit stream in transmit order, first bit transmitted at bit 63.
    function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p,
                                                input logic [7:0] b);
        logic [63:0] w;
        w = '0;
        for (int dig = 7; dig >= 0; dig--) begin
            w = {w[55:0], model_byte((d >> (4 * dig)) & 32'hF, p[dig], b[dig])};
        end
        return w;
    endfunction

    // ---------------- monitor ----------------
    logic [63:0] acc_seg = '0;
    logic [15:0] acc_led = '0;
    int acc_seg_n = 0, acc_led_n = 0, busy_len = 0, idle_len = 0;
    logic [63:0] got_seg = '0;
    logic [15:0] got_led = '0;
    int got_seg_n = 0, got_led_n = 0, got_len = 0, got_gap = 0;
    int frames_done = 0, total_rises = 0, busy_total = 0, inv_err = 0;
    logic prev_seg_clk = 1'b0, prev_led_clk = 1'b0, prev_busy = 1'b0, prev_sout = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            acc_seg = '0; acc_led = '0; acc_seg_n = 0; acc_led_n = 0;
            busy_len = 0; idle_len = 0;
            prev_seg_clk = 1'b0; prev_led_clk = 1'b0; prev_busy = 1'b0; prev_sout = 1'b1;
        end else begin
            if (bus.seg_clk && !prev_seg_clk) begin
                acc_seg = {acc_seg[62:0], bus.seg_sout};
                acc_seg_n++;
                total_rises++;
            end
            if (bus.led_clk && !prev_led_clk) begin
                acc_led = {acc_led[14:0], bus.led_sout};
                acc_led_n++;
            end
            if (bus.seg_clk && prev_seg_clk && (bus.seg_sout !== prev_sout)) inv_err++;
            if (bus.busy) begin
                if (!prev_busy) begin
                    got_gap  = idle_len;
                    busy_len = 0;
                end
                busy_len++;
                busy_total++;
            end else begin
                if (prev_busy) begin
                    got_seg = acc_seg; got_led = acc_led;
                    got_seg_n = acc_seg_n; got_led_n = acc_led_n; got_len = busy_len;
                    frames_done++;
                    acc_seg = '0; acc_led = '0; acc_seg_n = 0; acc_led_n = 0;
                    idle_len = 0;
                end
                idle_len++;
                if (bus.seg_clk !== 1'b0 || bus.seg_sout !== 1'b1 || bus.seg_pen !== 1'b0 ||
                    bus.led_clk !== 1'b0 || bus.led_sout !== 1'b1 || bus.led_pen !== 1'b0)
                    inv_err++;
            end
`ifndef OUTPUT_SEG_LED_CHAIN_EN
            if (bus.led_clk !== 1'b0 || bus.led_sout !== 1'b1 || bus.led_pen !== 1'b0) inv_err++;
`endif
            prev_seg_clk = bus.seg_clk;
            prev_led_clk = bus.led_clk;
            prev_busy    = bus.busy;
            prev_sout    = bus.seg_sout;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                         input logic [15:0] l);
        bus.seg_data  = d;
        bus.seg_point = p;
        bus.seg_blank = b;
        bus.led_data  = l;
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        int start_n;
        start_n = frames_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (frames_done != start_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_slot(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (acc_seg_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic frame_check(input string name, input logic [63:0] es, input logic [15:0] lv);
        bit ok;
        wait_frame(1500, ok);
        check({name, " done"}, 64'(ok), 64'd1);
        check({name, " seg"}, got_seg, es);
        check({name, " seg_bits"}, 64'(got_seg_n), 64'd64);
`ifdef OUTPUT_SEG_LED_CHAIN_EN
        check({name, " led"}, 64'(got_led), 64'(~lv));
        check({name, " led_bits"}, 64'(got_led_n), 64'd16);
`else
        check({name, " led_bits"}, 64'(got_led_n + int'(lv & 16'h0)), 64'd0);
`endif
        check({name, " busy_len"}, 64'(got_len), 64'(FRAME_LEN));
    endtask

    function automatic logic [8:0] pins();
        return {bus.seg_clk, bus.seg_sout, bus.seg_pen, bus.seg_clrn,
                bus.led_clk, bus.led_sout, bus.led_pen, bus.led_clrn, bus.busy};
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [7:0]  point;
        logic [7:0]  blank;
        logic [15:0] led;
        logic [7:0]  first;
        logic [7:0]  last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0, r0, b0;
        logic [31:0] nd;
        logic [7:0]  np, nb;
        logic [15:0] nl;

        vecs[0] = '{32'h7654_3210, 8'h00, 8'h00, 16'h1234, 8'hF8, 8'hC0};
        vecs[1] = '{32'h7654_3210, 8'h01, 8'h80, 16'hA5A5, 8'hFF, 8'h40};
        vecs[2] = '{32'hFEDC_BA98, 8'hFF, 8'h00, 16'h0000, 8'h0E, 8'h00};
        vecs[3] = '{32'h0123_4567, 8'h00, 8'h00, 16'hFFFF, 8'hC0, 8'hF8};
        vecs[4] = '{32'h89AB_CDEF, 8'h00, 8'h7E, 16'h8001, 8'h80, 8'h8E};

        // Reset state
        apply(32'h0123_4567, 8'h00, 8'h00, 16'h0F0F);
        repeat (3) step();
        check("reset_pins", 64'(pins()), 64'(9'b0_1_0_0_0_1_0_0_0));

        // Release: clear lifts and the first frame starts on the same edge
        rst = 1'b0;
        step();
        check("release_clrn_busy", 64'({bus.seg_clrn, bus.led_clrn, bus.busy}), 64'(3'b111));
        frame_check("first", model_frame(32'h0123_4567, 8'h00, 8'h00), 16'h0F0F);
        check("first_byte0", 64'(got_seg[63:56]), 64'h0C0);
        check("first_byte7", 64'(got_seg[7:0]), 64'h0F8);

        // No change: no frame
        n0 = frames_done; r0 = total_rises; b0 = busy_total;
        repeat (1000) step();
        check("quiet_frames", 64'(frames_done - n0), 64'd0);
        check("quiet_rises", 64'(total_rises - r0), 64'd0);
        check("quiet_busy", 64'(busy_total - b0), 64'd0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            apply(vecs[i].data, vecs[i].point, vecs[i].blank, vecs[i].led);
            frame_check($sformatf("vec%0d", i),
                        model_frame(vecs[i].data, vecs[i].point, vecs[i].blank), vecs[i].led);
            check($sformatf("vec%0d first", i), 64'(got_seg[63:56]), 64'(vecs[i].first));
            check($sformatf("vec%0d last", i), 64'(got_seg[7:0]), 64'(vecs[i].last));
            check($sformatf("vec%0d gap", i), 64'(got_gap >= 1), 64'd1);
        end

        // Randomized
        for (int i = 0; i < 12; i++) begin
            nd = $urandom;
            if (nd == bus.seg_data) nd = nd ^ 32'h1;
            np = 8'($urandom_range(0, 255));
            nb = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            nl = 16'($urandom_range(0, 65535));
            apply(nd, np, nb, nl);
            frame_check($sformatf("rand%0d", i), model_frame(nd, np, nb), nl);
        end

        // led_data change mid-frame
        apply(32'hCAFE_0042, 8'h10, 8'h00, 16'h0001);
        wait_slot(30, ok);
        check("ledmid slot", 64'(ok), 64'd1);
        bus.led_data = 16'h8000;
        frame_check("ledmid f1", model_frame(32'hCAFE_0042, 8'h10, 8'h00), 16'h0001);
`ifdef OUTPUT_SEG_LED_CHAIN_EN
        frame_check("ledmid f2", model_frame(32'hCAFE_0042, 8'h10, 8'h00), 16'h8000);
        check("ledmid gap", 64'(got_gap >= 1), 64'd1);
`else
        n0 = frames_done;
        repeat (600) step();
        check("ledonly no_frame", 64'(frames_done - n0), 64'd0);
`endif

        // seg_data change mid-frame
        apply(32'h1357_9BDF, 8'h00, 8'h00, bus.led_data);
        wait_slot(30, ok);
        check("segmid slot", 64'(ok), 64'd1);
        bus.seg_data = 32'h2468_ACE0;
        frame_check("segmid f1", model_frame(32'h1357_9BDF, 8'h00, 8'h00), bus.led_data);
        frame_check("segmid f2", model_frame(32'h2468_ACE0, 8'h00, 8'h00), bus.led_data);
        check("segmid gap", 64'(got_gap >= 1), 64'd1);

        // Reset pulse in slot 40
        apply(32'hDEAD_BEEF, 8'hA5, 8'h00, 16'h5A5A);
        wait_slot(40, ok);
        check("rstmid slot", 64'(ok), 64'd1);
        n0 = frames_done;
        rst = 1'b1;
        step();
        check("rstmid pins", 64'(pins()), 64'(9'b0_1_0_0_0_1_0_0_0));
        rst = 1'b0;
        step();
        check("rstmid restart", 64'({bus.seg_clrn, bus.busy}), 64'(2'b11));
        frame_check("rstmid frame", model_frame(32'hDEAD_BEEF, 8'hA5, 8'h00), 16'h5A5A);
        check("rstmid aborted_not_counted", 64'(frames_done - n0), 64'd1);

        check("idle_and_hold_invariants", 64'(inv_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
